// File: rtl/systolic_2x2.sv
// Output-stationary 2x2 systolic matrix multiplier (C = A x B), unsigned.
// Ports: clk, rst (async, active-high), a1/a2 row streams, b1/b2 column
// streams, c11..c22 registered results, done (sticky completion flag).

module systolic_pe #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DATA_W-1:0] a_in,
    input  logic [DATA_W-1:0] b_in,
    output logic [DATA_W-1:0] a_out,
    output logic [DATA_W-1:0] b_out,
    output logic [ACC_W-1:0]  acc
);

    logic [2*DATA_W-1:0] prod;

    assign prod = a_in * b_in;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_out <= '0;
            b_out <= '0;
            acc   <= '0;
        end else if (en) begin
            a_out <= a_in;
            b_out <= b_in;
            // wraps modulo 2^ACC_W
            acc   <= acc + ACC_W'(prod);
        end
    end

endmodule

module systolic_2x2 #(
    parameter int DATA_W      = 8,
    parameter int ACC_W       = 16,
    parameter int DONE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] a1,
    input  logic [DATA_W-1:0] a2,
    input  logic [DATA_W-1:0] b1,
    input  logic [DATA_W-1:0] b2,
    output logic [ACC_W-1:0]  c11,
    output logic [ACC_W-1:0]  c12,
    output logic [ACC_W-1:0]  c21,
    output logic [ACC_W-1:0]  c22,
    output logic              done
);

    localparam logic [2:0] LAST_CNT = 3'(DONE_CYCLES - 1);

    logic [2:0]        cnt;
    logic              en;
    logic [DATA_W-1:0] a11_out, b11_out;
    logic [DATA_W-1:0] a12_out, b12_out;
    logic [DATA_W-1:0] a21_out, b21_out;
    logic [DATA_W-1:0] a22_out, b22_out;

    // once done, the whole array freezes
    assign en = ~done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            done <= 1'b0;
        end else if (!done) begin
            cnt <= cnt + 3'd1;
            // edge on which cnt reaches DONE_CYCLES
            if (cnt == LAST_CNT)
                done <= 1'b1;
        end
    end

    systolic_pe #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_pe11 (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .a_in  (a1),
        .b_in  (b1),
        .a_out (a11_out),
        .b_out (b11_out),
        .acc   (c11)
    );

    systolic_pe #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_pe12 (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .a_in  (a11_out),
        .b_in  (b2),
        .a_out (a12_out),
        .b_out (b12_out),
        .acc   (c12)
    );

    systolic_pe #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_pe21 (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .a_in  (a2),
        .b_in  (b11_out),
        .a_out (a21_out),
        .b_out (b21_out),
        .acc   (c21)
    );

    systolic_pe #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_pe22 (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .a_in  (a21_out),
        .b_in  (b12_out),
        .a_out (a22_out),
        .b_out (b22_out),
        .acc   (c22)
    );

    // edge-column operands leave the array unused
    logic unused;
    assign unused = ^{a12_out, a22_out, b21_out, b22_out};

endmodule

// File: tb/tb_systolic_2x2.sv
// Directed self-checking bench for systolic_2x2.
// Hand-computed matrix products, freeze, async reset and latency checks.

module tb_systolic_2x2;

    logic        clk;
    logic        rst;
    logic [7:0]  a1, a2, b1, b2;
    logic [15:0] c11, c12, c21, c22;
    logic        done;

    int vectors;
    int fails;

    systolic_2x2 dut (
        .clk  (clk),
        .rst  (rst),
        .a1   (a1),
        .a2   (a2),
        .b1   (b1),
        .b2   (b2),
        .c11  (c11),
        .c12  (c12),
        .c21  (c21),
        .c22  (c22),
        .done (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int e11, input int e12,
                           input int e21, input int e22, input int ed);
        chk({tag, ".c11"}, int'(c11), e11);
        chk({tag, ".c12"}, int'(c12), e12);
        chk({tag, ".c21"}, int'(c21), e21);
        chk({tag, ".c22"}, int'(c22), e22);
        chk({tag, ".done"}, int'(done), ed);
    endtask

    // drive one diagonal, take the edge, settle 1ns past it
    task automatic step(input logic [7:0] va1, input logic [7:0] va2,
                        input logic [7:0] vb1, input logic [7:0] vb2);
        a1 = va1;
        a2 = va2;
        b1 = vb1;
        b2 = vb2;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        a1 = '0;
        a2 = '0;
        b1 = '0;
        b2 = '0;
        repeat (n) @(posedge clk);
        #1;
        chk_all("reset_held", 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        vectors = 0;
        fails   = 0;
        rst = 1'b1;
        a1 = '0;
        a2 = '0;
        b1 = '0;
        b2 = '0;

        // basic: A=[[1,2],[3,4]] B=[[5,6],[7,8]]
        do_reset(5);
        step(8'd1, 8'd0, 8'd5, 8'd0);
        chk_all("basic_e1", 5, 0, 0, 0, 0);
        step(8'd2, 8'd3, 8'd7, 8'd6);
        chk("basic_e2.c11", int'(c11), 19);
        chk("basic_e2.done", int'(done), 0);
        step(8'd0, 8'd4, 8'd0, 8'd8);
        chk_all("basic_e3", 19, 22, 43, 18, 0);
        step(8'd0, 8'd0, 8'd0, 8'd0);
        chk_all("basic_e4", 19, 22, 43, 50, 1);

        // freeze: garbage after done is ignored
        for (int i = 0; i < 5; i++)
            step(8'd100, 8'd100, 8'd100, 8'd100);
        chk_all("freeze", 19, 22, 43, 50, 1);

        // async reset between edges 2 and 3
        do_reset(2);
        step(8'd1, 8'd0, 8'd5, 8'd0);
        step(8'd2, 8'd3, 8'd7, 8'd6);
        #2;
        rst = 1'b1;
        #1;
        chk_all("async_rst", 0, 0, 0, 0, 0);
        do_reset(2);
        step(8'd1, 8'd0, 8'd5, 8'd0);
        step(8'd2, 8'd3, 8'd7, 8'd6);
        step(8'd0, 8'd4, 8'd0, 8'd8);
        chk("rerun_e3.done", int'(done), 0);
        step(8'd0, 8'd0, 8'd0, 8'd0);
        chk_all("rerun_e4", 19, 22, 43, 50, 1);

        // max operands: 2*255*255 mod 2^16
        do_reset(2);
        step(8'd255, 8'd0, 8'd255, 8'd0);
        step(8'd255, 8'd255, 8'd255, 8'd255);
        step(8'd0, 8'd255, 8'd0, 8'd255);
        chk("max_e3.done", int'(done), 0);
        step(8'd0, 8'd0, 8'd0, 8'd0);
        chk_all("max_e4", 64514, 64514, 64514, 64514, 1);

        // identity: A=I, B=[[9,8],[7,6]]
        do_reset(2);
        step(8'd1, 8'd0, 8'd9, 8'd0);
        step(8'd0, 8'd0, 8'd7, 8'd8);
        step(8'd0, 8'd1, 8'd0, 8'd6);
        step(8'd0, 8'd0, 8'd0, 8'd0);
        chk_all("ident", 9, 8, 7, 6, 1);

        // zero operands: done still comes at edge 4
        do_reset(2);
        step(8'd0, 8'd0, 8'd0, 8'd0);
        step(8'd0, 8'd0, 8'd0, 8'd0);
        step(8'd0, 8'd0, 8'd0, 8'd0);
        chk("zero_e3.done", int'(done), 0);
        step(8'd0, 8'd0, 8'd0, 8'd0);
        chk_all("zero_e4", 0, 0, 0, 0, 1);
        repeat (3) step(8'd0, 8'd0, 8'd0, 8'd0);
        chk("zero_sticky.done", int'(done), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
